dcache_ctrl_assoc: RTL

//  Parametrised data-cache controller: N-way set-associative, write-back, write-allocate.

---
 rtl/dcache_pkg.sv | 30 +++
 rtl/dcache_line_buffer.sv | 55 +++++
 rtl/dcache_ctrl_assoc.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the set-associative data-cache controller:
// FSM state encoding, default derived geometry and an index-width helper.
package dcache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WB_REQ  = 3'd1,
    ST_WB_DATA = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_FILL    = 3'd5
  } state_e;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_WORD_W      = 32;
  localparam int DEF_BLOCK_WORDS = 4;
  localparam int DEF_WAYS        = 2;
  localparam int DEF_BEAT_W      = 32;

  localparam int LINE_W  = DEF_BLOCK_WORDS * DEF_WORD_W;
  localparam int BEATS   = LINE_W / DEF_BEAT_W;
  localparam int OFF_W   = $clog2(LINE_W / 8);
  localparam int LADDR_W = DEF_ADDR_W - OFF_W;

  // Width of an index over n items; never zero so that n==1 still gets a legal vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dcache_line_buffer.sv
// Refill line buffer: collects memory beats by index, muxes one beat out of a
// supplied line, and merges a pending store word into the collected line.
module dcache_line_buffer
  import dcache_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int BEAT_W      = 32,
  localparam int LINE_W = BLOCK_WORDS * WORD_W,
  localparam int BEATS  = LINE_W / BEAT_W,
  localparam int BC_W   = idx_w(BEATS),
  localparam int WOFF_W = idx_w(BLOCK_WORDS),
  localparam int BSEL_W = WORD_W / 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              beat_we,
  input  logic [BC_W-1:0]   beat_idx,
  input  logic [BEAT_W-1:0] beat_wdata,
  input  logic [LINE_W-1:0] rd_line,
  output logic [BEAT_W-1:0] rd_beat,
  input  logic              store_en,
  input  logic [WOFF_W-1:0] store_woff,
  input  logic [BSEL_W-1:0] store_bsel,
  input  logic [WORD_W-1:0] store_din,
  output logic [LINE_W-1:0] merged_line
);

  logic [LINE_W-1:0] buf_r;

  // Capture one refill beat at its position in the line.
  always_ff @(posedge clock) begin
    if (reset) begin
      buf_r <= {LINE_W{1'b0}};
    end else if (beat_we) begin
      buf_r[beat_idx*BEAT_W +: BEAT_W] <= beat_wdata;
    end
  end

  // Beat selection out of an arbitrary line (victim writeback source).
  always_comb begin
    rd_beat = rd_line[beat_idx*BEAT_W +: BEAT_W];
  end

  // Overlay the latched store bytes onto the refilled line.
  always_comb begin
    merged_line = buf_r;
    for (int b = 0; b < BSEL_W; b++) begin
      merged_line[store_woff*WORD_W + b*8 +: 8] =
        (store_en && store_bsel[b]) ? store_din[b*8 +: 8]
                                    : buf_r[store_woff*WORD_W + b*8 +: 8];
    end
  end

endmodule

// File: rtl/dcache_ctrl_assoc.sv
// N-way set-associative write-back, write-allocate data-cache controller with
// round-robin victim choice and a burst memory interface.
module dcache_ctrl_assoc
  import dcache_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int WAYS        = 2,
  parameter int BEAT_W      = 32,
  localparam int LINE_W  = BLOCK_WORDS * WORD_W,
  localparam int OFF_W   = $clog2(LINE_W / 8),
  localparam int LADDR_W = ADDR_W - OFF_W,
  localparam int BE_W    = LINE_W / 8,
  localparam int BSEL_W  = WORD_W / 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cpu_ren,
  input  logic               cpu_wen,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [BSEL_W-1:0]  cpu_bsel,
  input  logic [WORD_W-1:0]  cpu_din,
  output logic [WORD_W-1:0]  cpu_dout,
  output logic               cpu_stall,
  output logic [LADDR_W-1:0] cache_laddr,
  input  logic [WAYS-1:0]    cache_hit,
  input  logic [WAYS-1:0]    cache_valid,
  input  logic [WAYS-1:0]    cache_dirty,
  output logic [WAYS-1:0]    cache_way,
  input  logic [LADDR_W-1:0] cache_rtag_laddr,
  input  logic [LINE_W-1:0]  cache_rdata,
  output logic               cache_wen,
  output logic [BE_W-1:0]    cache_be,
  output logic [LINE_W-1:0]  cache_wdata,
  output logic               cache_set_dirty,
  output logic               mem_req,
  output logic               mem_we,
  output logic [LADDR_W-1:0] mem_laddr,
  input  logic               mem_gnt,
  output logic [BEAT_W-1:0]  mem_wdata,
  input  logic               mem_wready,
  input  logic [BEAT_W-1:0]  mem_rdata,
  input  logic               mem_rvalid
);

  localparam int BEATS  = LINE_W / BEAT_W;
  localparam int BC_W   = idx_w(BEATS);
  localparam int RR_W   = idx_w(WAYS);
  localparam int WOFF_W = idx_w(BLOCK_WORDS);
  localparam int BOFF_W = $clog2(BSEL_W);

  state_e             state_r;
  logic [RR_W-1:0]    rr_ptr_r;
  logic [BC_W-1:0]    beat_cnt_r;
  logic [WAYS-1:0]    victim_way_r;
  logic [LADDR_W-1:0] victim_laddr_r;
  logic [LADDR_W-1:0] miss_laddr_r;
  logic [LADDR_W-1:0] mem_laddr_r;
  logic               mem_req_r;
  logic               mem_we_r;
  logic               store_r;
  logic               rr_used_r;
  logic [WORD_W-1:0]  din_r;
  logic [BSEL_W-1:0]  bsel_r;
  logic [WOFF_W-1:0]  woff_r;

  logic               req_s;
  logic               hit_s;
  logic               last_beat_s;
  logic [OFF_W-1:0]   off_s;
  logic [WOFF_W-1:0]  woff_s;
  logic [LADDR_W-1:0] cpu_laddr_s;
  logic [WAYS-1:0]    invalid_pick_s;
  logic [WAYS-1:0]    victim_s;
  logic               rr_pick_s;
  logic               victim_dirty_s;
  logic [BEAT_W-1:0]  rd_beat_s;
  logic [LINE_W-1:0]  merged_s;

  // One-hot of the lowest-numbered invalid way, zero when the set is full.
  function automatic logic [WAYS-1:0] lowest_invalid(input logic [WAYS-1:0] valid);
    logic [WAYS-1:0] pick;
    pick = {WAYS{1'b0}};
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) begin
        pick = WAYS'(1'b1) << w;
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  assign req_s       = cpu_ren ^ cpu_wen;
  assign hit_s       = |cache_hit;
  assign last_beat_s = (beat_cnt_r == BC_W'(BEATS - 1));
  assign off_s       = cpu_addr[OFF_W-1:0];
  assign woff_s      = WOFF_W'(off_s >> BOFF_W);
  assign cpu_laddr_s = cpu_addr[ADDR_W-1:OFF_W];
  assign mem_req     = mem_req_r;
  assign mem_we      = mem_we_r;
  assign mem_laddr   = mem_laddr_r;

  // Victim choice: an empty way first, otherwise the round-robin pointer.
  always_comb begin
    invalid_pick_s = lowest_invalid(cache_valid);
    if (|invalid_pick_s) begin
      victim_s  = invalid_pick_s;
      rr_pick_s = 1'b0;
    end else begin
      victim_s  = WAYS'(1'b1) << rr_ptr_r;
      rr_pick_s = 1'b1;
    end
    victim_dirty_s = |(victim_s & cache_valid & cache_dirty);
  end

  // Load data always tracks the word of the currently selected way.
  always_comb begin
    cpu_dout = cache_rdata[woff_s*WORD_W +: WORD_W];
  end

  dcache_line_buffer #(
    .WORD_W      (WORD_W),
    .BLOCK_WORDS (BLOCK_WORDS),
    .BEAT_W      (BEAT_W)
  ) u_line_buffer (
    .clock       (clock),
    .reset       (reset),
    .beat_we     ((state_r == ST_RD_DATA) && mem_rvalid),
    .beat_idx    (beat_cnt_r),
    .beat_wdata  (mem_rdata),
    .rd_line     (cache_rdata),
    .rd_beat     (rd_beat_s),
    .store_en    (store_r),
    .store_woff  (woff_r),
    .store_bsel  (bsel_r),
    .store_din   (din_r),
    .merged_line (merged_s)
  );

  // Array/pipeline strobes; hits are resolved in the same cycle, so these decode live inputs.
  always_comb begin
    cpu_stall       = 1'b0;
    cache_way       = {WAYS{1'b0}};
    cache_wen       = 1'b0;
    cache_be        = {BE_W{1'b0}};
    cache_wdata     = {LINE_W{1'b0}};
    cache_set_dirty = 1'b0;
    cache_laddr     = cpu_laddr_s;
    mem_wdata       = {BEAT_W{1'b0}};
    if (reset) begin
      cpu_stall = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_s && hit_s) begin
            cache_way = cache_hit;
            if (cpu_wen) begin
              cache_wen       = 1'b1;
              cache_be        = BE_W'(cpu_bsel) << (woff_s * BSEL_W);
              cache_wdata     = {BLOCK_WORDS{cpu_din}};
              cache_set_dirty = 1'b1;
            end else begin
              cache_wen = 1'b0;
            end
          end else if (req_s) begin
            cpu_stall = 1'b1;
            cache_way = victim_s;
          end else begin
            cpu_stall = 1'b0;
          end
        end
        ST_WB_REQ: begin
          cpu_stall   = 1'b1;
          cache_way   = victim_way_r;
          cache_laddr = victim_laddr_r;
        end
        ST_WB_DATA: begin
          cpu_stall   = 1'b1;
          cache_way   = victim_way_r;
          cache_laddr = victim_laddr_r;
          mem_wdata   = rd_beat_s;
        end
        ST_RD_REQ, ST_RD_DATA: begin
          cpu_stall = 1'b1;
          cache_way = victim_way_r;
        end
        ST_FILL: begin
          cpu_stall       = 1'b1;
          cache_way       = victim_way_r;
          cache_wen       = 1'b1;
          cache_be        = {BE_W{1'b1}};
          cache_wdata     = merged_s;
          cache_set_dirty = store_r;
        end
        default: begin
          cpu_stall = 1'b1;
        end
      endcase
    end
  end

  // Miss-handling FSM with registered memory request, direction and address.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      rr_ptr_r       <= {RR_W{1'b0}};
      beat_cnt_r     <= {BC_W{1'b0}};
      victim_way_r   <= {WAYS{1'b0}};
      victim_laddr_r <= {LADDR_W{1'b0}};
      miss_laddr_r   <= {LADDR_W{1'b0}};
      mem_laddr_r    <= {LADDR_W{1'b0}};
      mem_req_r      <= 1'b0;
      mem_we_r       <= 1'b0;
      store_r        <= 1'b0;
      rr_used_r      <= 1'b0;
      din_r          <= {WORD_W{1'b0}};
      bsel_r         <= {BSEL_W{1'b0}};
      woff_r         <= {WOFF_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_s && !hit_s) begin
            victim_way_r   <= victim_s;
            victim_laddr_r <= cache_rtag_laddr;
            miss_laddr_r   <= cpu_laddr_s;
            store_r        <= cpu_wen;
            rr_used_r      <= rr_pick_s;
            din_r          <= cpu_din;
            bsel_r         <= cpu_bsel;
            woff_r         <= woff_s;
            beat_cnt_r     <= {BC_W{1'b0}};
            mem_req_r      <= 1'b1;
            if (victim_dirty_s) begin
              state_r     <= ST_WB_REQ;
              mem_we_r    <= 1'b1;
              mem_laddr_r <= cache_rtag_laddr;
            end else begin
              state_r     <= ST_RD_REQ;
              mem_we_r    <= 1'b0;
              mem_laddr_r <= cpu_laddr_s;
            end
          end
        end
        ST_WB_REQ: begin
          if (mem_gnt) begin
            state_r    <= ST_WB_DATA;
            mem_req_r  <= 1'b0;
            beat_cnt_r <= {BC_W{1'b0}};
          end
        end
        ST_WB_DATA: begin
          if (mem_wready) begin
            if (last_beat_s) begin
              state_r     <= ST_RD_REQ;
              beat_cnt_r  <= {BC_W{1'b0}};
              mem_req_r   <= 1'b1;
              mem_we_r    <= 1'b0;
              mem_laddr_r <= miss_laddr_r;
            end else begin
              beat_cnt_r <= beat_cnt_r + BC_W'(1'b1);
            end
          end
        end
        ST_RD_REQ: begin
          if (mem_gnt) begin
            state_r    <= ST_RD_DATA;
            mem_req_r  <= 1'b0;
            beat_cnt_r <= {BC_W{1'b0}};
          end
        end
        ST_RD_DATA: begin
          if (mem_rvalid) begin
            if (last_beat_s) begin
              state_r    <= ST_FILL;
              beat_cnt_r <= {BC_W{1'b0}};
            end else begin
              beat_cnt_r <= beat_cnt_r + BC_W'(1'b1);
            end
          end
        end
        ST_FILL: begin
          state_r <= ST_IDLE;
          // Only a round-robin eviction consumes the pointer; WAYS==1 keeps it at zero.
          if (rr_used_r && (WAYS > 1)) begin
            rr_ptr_r <= rr_ptr_r + RR_W'(1'b1);
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
